// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the requesters, the arbiter and the UART byte channel.
//   req_valid  [NREQ]             requester byte valid
//   req_ready  [NREQ]             requester byte accepted (driven by the arbiter)
//   req_bits   [NREQ*DATA_WIDTH]  requester i byte in [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last   [NREQ]             final byte of a packet
//   uart_valid                    byte valid towards the UART (driven by the arbiter)
//   uart_ready                    UART accepts the byte
//   uart_bits  [DATA_WIDTH]       byte towards the UART (driven by the arbiter)
// master: the arbiter. slave: the requesters plus the UART.
interface uart_tx_arbiter_if #(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ*DATA_WIDTH-1:0] req_bits;
  logic [NREQ-1:0]            req_last;
  logic                       uart_valid;
  logic                       uart_ready;
  logic [DATA_WIDTH-1:0]      uart_bits;

  modport master (
    input  req_valid, req_bits, req_last, uart_ready,
    output req_ready, uart_valid, uart_bits
  );

  modport slave (
    output req_valid, req_bits, req_last, uart_ready,
    input  req_ready, uart_valid, uart_bits
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter in front of a UART transmit byte channel.
// A granted requester keeps the lock until its last byte or an idle timeout;
// each packet is optionally preceded by a tag byte 0x30+grant_id.
// Ports:
//   clock          rising-edge clock
//   reset          synchronous, active-high
//   bus            uart_tx_arbiter_if.master (requester and UART handshakes)
//   grant_id       current or last granted requester
//   busy           state is not IDLE
//   timeout_pulse  one cycle when a lock is dropped by timeout
//
// state | meaning
// IDLE  | no lock; pick next valid requester after rr_ptr
// TAG   | lock held; waiting to load the tag byte
// DATA  | lock held; forwarding the granted requester's bytes
module uart_tx_arbiter #(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 64,
  parameter int PREFIX_EN  = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  uart_tx_arbiter_if.master       bus,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic                    timeout_pulse
);
  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_TAG  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam logic [CW-1:0]         CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [DATA_WIDTH-1:0] TAG_BASE = DATA_WIDTH'(8'h30);

  logic [1:0]            state_q, state_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [GW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  uart_valid_q, uart_valid_d;
  logic [DATA_WIDTH-1:0] uart_bits_q, uart_bits_d;
  logic                  tpulse_q, tpulse_d;

  logic                  can_load;
  logic [NREQ-1:0]       ready_mask;
  logic                  gnt_valid;
  logic                  gnt_last;
  logic [DATA_WIDTH-1:0] gnt_bits;
  logic                  xfer;
  logic                  any_valid;
  logic [GW-1:0]         pick;

  assign can_load  = !uart_valid_q || bus.uart_ready;
  assign gnt_valid = bus.req_valid[grant_q];
  assign gnt_last  = bus.req_last[grant_q];
  assign gnt_bits  = bus.req_bits[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];

  // Ready is combinational from uart_ready and masked by reset so nothing
  // is accepted on the edge that discards the lock.
  always_comb begin
    ready_mask = '0;
    if (state_q == ST_DATA && can_load && !reset) ready_mask[grant_q] = 1'b1;
  end

  assign xfer = gnt_valid && ready_mask[grant_q];

  // First valid requester starting one past the last lock owner.
  always_comb begin
    any_valid = 1'b0;
    pick      = rr_ptr_q;
    for (int i = 1; i <= NREQ; i++) begin
      int idx;
      idx = (int'(rr_ptr_q) + i) % NREQ;
      if (!any_valid && bus.req_valid[idx]) begin
        any_valid = 1'b1;
        pick      = GW'(idx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    uart_valid_d = uart_valid_q;
    uart_bits_d  = uart_bits_q;
    tpulse_d     = 1'b0;
    if (can_load) uart_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          grant_d = pick;
          cnt_d   = '0;
          state_d = (PREFIX_EN != 0) ? ST_TAG : ST_DATA;
        end
      end
      ST_TAG: begin
        if (can_load) begin
          uart_valid_d = 1'b1;
          uart_bits_d  = TAG_BASE + DATA_WIDTH'(grant_q);
          cnt_d        = '0;
          state_d      = ST_DATA;
        end
      end
      ST_DATA: begin
        // A transfer always takes precedence over an expiring idle count.
        if (xfer) begin
          uart_valid_d = 1'b1;
          uart_bits_d  = gnt_bits;
          cnt_d        = '0;
          if (gnt_last) begin
            rr_ptr_d = grant_q;
            state_d  = ST_IDLE;
          end
        end else if (!gnt_valid) begin
          if (cnt_q == CNT_LAST) begin
            tpulse_d = 1'b1;
            rr_ptr_d = grant_q;
            cnt_d    = '0;
            state_d  = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      rr_ptr_q     <= GW'(NREQ - 1);
      cnt_q        <= '0;
      uart_valid_q <= 1'b0;
      uart_bits_q  <= '0;
      tpulse_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      uart_valid_q <= uart_valid_d;
      uart_bits_q  <= uart_bits_d;
      tpulse_q     <= tpulse_d;
    end
  end

  assign bus.req_ready  = ready_mask;
  assign bus.uart_valid = uart_valid_q;
  assign bus.uart_bits  = uart_bits_q;
  assign grant_id       = grant_q;
  assign busy           = (state_q != ST_IDLE);
  assign timeout_pulse  = tpulse_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: dut_a uses the tag prefix, dut_b does not.
module tb_uart_tx_arbiter;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  uart_tx_arbiter_if #(.NREQ(4), .DATA_WIDTH(8)) a_if ();
  uart_tx_arbiter_if #(.NREQ(4), .DATA_WIDTH(8)) b_if ();

  logic [1:0] grant_a, grant_b;
  logic       busy_a, busy_b, tp_a, tp_b;

  uart_tx_arbiter #(.NREQ(4), .DATA_WIDTH(8), .TIMEOUT(64), .PREFIX_EN(1)) dut_a (
    .clock(clock), .reset(reset), .bus(a_if),
    .grant_id(grant_a), .busy(busy_a), .timeout_pulse(tp_a)
  );

  uart_tx_arbiter #(.NREQ(4), .DATA_WIDTH(8), .TIMEOUT(64), .PREFIX_EN(0)) dut_b (
    .clock(clock), .reset(reset), .bus(b_if),
    .grant_id(grant_b), .busy(busy_b), .timeout_pulse(tp_b)
  );

  int ncomp = 0;
  int nfail = 0;
  int tp_cnt = 0;

  logic [7:0] pq [4][$];
  logic       lq [4][$];
  logic [7:0] outlog [$];
  logic [7:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int r, input logic [7:0] b, input logic l);
    pq[r].push_back(b);
    lq[r].push_back(l);
  endtask

  function automatic logic pending();
    for (int i = 0; i < 4; i++) if (pq[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive_a();
    for (int i = 0; i < 4; i++) begin
      if (pq[i].size() != 0) begin
        a_if.req_valid[i]        = 1'b1;
        a_if.req_bits[i*8 +: 8]  = pq[i][0];
        a_if.req_last[i]         = lq[i][0];
      end else begin
        a_if.req_valid[i]        = 1'b0;
        a_if.req_bits[i*8 +: 8]  = 8'h00;
        a_if.req_last[i]         = 1'b0;
      end
    end
  endtask

  // One clock: sample handshakes mid-cycle, advance past the edge, then
  // retire accepted requester bytes and log bytes the UART took.
  task automatic tick();
    logic [3:0] xf;
    logic       acc;
    logic [7:0] ab;
    @(negedge clock);
    xf  = a_if.req_valid & a_if.req_ready;
    acc = a_if.uart_valid & a_if.uart_ready;
    ab  = a_if.uart_bits;
    @(posedge clock);
    #1;
    if (acc) outlog.push_back(ab);
    for (int i = 0; i < 4; i++) begin
      if (xf[i]) begin
        void'(pq[i].pop_front());
        void'(lq[i].pop_front());
      end
    end
    if (tp_a) tp_cnt++;
    drive_a();
  endtask

  task automatic do_reset();
    for (int i = 0; i < 4; i++) begin
      pq[i].delete();
      lq[i].delete();
    end
    drive_a();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((pending() || a_if.uart_valid || busy_a) && n < 300) begin
      tick();
      n++;
    end
    check("drain_bound", 32'(n < 300), 32'd1);
  endtask

  task automatic check_log(input string tag);
    logic [31:0] o;
    check({tag, "_len"}, outlog.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      o = 'x;
      if (i < outlog.size()) o = 32'(outlog[i]);
      check($sformatf("%s_%0d", tag, i), o, 32'(exp_q[i]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    a_if.uart_ready = 1'b1;
    b_if.uart_ready = 1'b1;
    b_if.req_valid  = '0;
    b_if.req_bits   = '0;
    b_if.req_last   = '0;
    drive_a();

    // Reset state
    do_reset();
    check("rst_uart_valid", a_if.uart_valid, 0);
    check("rst_uart_bits", a_if.uart_bits, 0);
    check("rst_grant", grant_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_timeout", tp_a, 0);
    check("rst_req_ready", a_if.req_ready, 0);
    check("rst_b_uart_valid", b_if.uart_valid, 0);

    // Two-byte packet from requester 0: tag, 0x41, 0x42 on consecutive cycles
    outlog.delete();
    push(0, 8'h41, 1'b0);
    push(0, 8'h42, 1'b1);
    drive_a();
    tick();
    check("p1_e1_busy", busy_a, 1);
    check("p1_e1_grant", grant_a, 0);
    check("p1_e1_uvalid", a_if.uart_valid, 0);
    tick();
    check("p1_e2_uvalid", a_if.uart_valid, 1);
    check("p1_e2_tag", a_if.uart_bits, 8'h30);
    check("p1_e2_ready", a_if.req_ready, 4'b0001);
    tick();
    check("p1_e3_byte", a_if.uart_bits, 8'h41);
    tick();
    check("p1_e4_byte", a_if.uart_bits, 8'h42);
    check("p1_e4_busy", busy_a, 0);
    tick();
    check("p1_e5_uvalid", a_if.uart_valid, 0);
    exp_q = '{8'h30, 8'h41, 8'h42};
    check_log("p1_log");

    // Requesters 0 and 2 contend, then a round starting after requester 2
    do_reset();
    outlog.delete();
    push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b0); push(0, 8'hA2, 1'b1);
    push(2, 8'hC0, 1'b0); push(2, 8'hC1, 1'b0); push(2, 8'hC2, 1'b1);
    drive_a();
    drain();
    exp_q = '{8'h30, 8'hA0, 8'hA1, 8'hA2, 8'h32, 8'hC0, 8'hC1, 8'hC2};
    check_log("rr_log");
    outlog.delete();
    push(0, 8'h10, 1'b1);
    push(3, 8'h13, 1'b1);
    drive_a();
    drain();
    exp_q = '{8'h33, 8'h13, 8'h30, 8'h10};
    check_log("rr2_log");

    // UART stall for 5 cycles mid-packet
    outlog.delete();
    push(1, 8'h51, 1'b0); push(1, 8'h52, 1'b0); push(1, 8'h53, 1'b0); push(1, 8'h54, 1'b1);
    drive_a();
    tick();
    tick();
    tick();
    check("st_grant", grant_a, 1);
    check("st_first", a_if.uart_bits, 8'h51);
    a_if.uart_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("st_bits_%0d", k), a_if.uart_bits, 8'h51);
      check($sformatf("st_valid_%0d", k), a_if.uart_valid, 1);
      check($sformatf("st_ready_%0d", k), a_if.req_ready, 0);
    end
    a_if.uart_ready = 1'b1;
    drain();
    exp_q = '{8'h31, 8'h51, 8'h52, 8'h53, 8'h54};
    check_log("st_log");

    // Requester 1 times out after 64 idle cycles; pending requester 3 next
    do_reset();
    tp_cnt = 0;
    outlog.delete();
    push(1, 8'h61, 1'b0);
    push(3, 8'h63, 1'b1);
    drive_a();
    tick();
    check("to_grant1", grant_a, 1);
    tick();
    tick();
    check("to_byte", a_if.uart_bits, 8'h61);
    repeat (63) tick();
    check("to_no_early", tp_cnt, 0);
    check("to_busy_held", busy_a, 1);
    tick();
    check("to_pulse", tp_a, 1);
    check("to_idle", busy_a, 0);
    tick();
    check("to_pulse_end", tp_a, 0);
    check("to_pulse_count", tp_cnt, 1);
    check("to_grant3", grant_a, 3);
    drain();
    exp_q = '{8'h31, 8'h61, 8'h33, 8'h63};
    check_log("to_log");

    // No prefix: single byte 0x55 visible after the second edge
    b_if.req_valid = 4'b0001;
    b_if.req_bits  = 32'h0000_0055;
    b_if.req_last  = 4'b0001;
    tick();
    check("np_e1_uvalid", b_if.uart_valid, 0);
    check("np_e1_busy", busy_b, 1);
    check("np_e1_ready", b_if.req_ready, 4'b0001);
    tick();
    check("np_e2_uvalid", b_if.uart_valid, 1);
    check("np_e2_bits", b_if.uart_bits, 8'h55);
    check("np_e2_busy", busy_b, 0);
    b_if.req_valid = '0;
    b_if.req_last  = '0;
    tick();
    check("np_e3_uvalid", b_if.uart_valid, 0);

    // Reset mid-packet discards the byte and the lock
    outlog.delete();
    push(2, 8'h71, 1'b0); push(2, 8'h72, 1'b0); push(2, 8'h73, 1'b1);
    drive_a();
    tick();
    tick();
    tick();
    check("mr_grant2", grant_a, 2);
    check("mr_byte", a_if.uart_bits, 8'h71);
    check("mr_uvalid", a_if.uart_valid, 1);
    reset = 1'b1;
    #1;
    check("mr_ready_in_reset", a_if.req_ready, 0);
    tick();
    check("mr_uvalid_after", a_if.uart_valid, 0);
    check("mr_bits_after", a_if.uart_bits, 0);
    check("mr_busy_after", busy_a, 0);
    check("mr_grant_after", grant_a, 0);
    reset = 1'b0;
    outlog.delete();
    push(0, 8'h80, 1'b1);
    drive_a();
    tick();
    check("mr_first_grant", grant_a, 0);
    check("mr_first_busy", busy_a, 1);
    drain();
    exp_q = '{8'h30, 8'h80, 8'h32, 8'h72, 8'h73};
    check_log("mr_log");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end
endmodule
